// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one external multiplier among N_REQ requesters.
// Optional statistics counters are enabled by defining MULT_SCHED_STATS_EN.
module mult_sched #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          en,
`ifdef MULT_SCHED_STATS_EN
    input  logic                          stat_clr,
    output logic [31:0]                   stat_issued,
    output logic [31:0]                   stat_stall,
`endif
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [32*N_REQ-1:0]           req_a,
    input  logic [32*N_REQ-1:0]           req_b,
    output logic [31:0]                   mult_a,
    output logic [31:0]                   mult_b,
    input  logic [63:0]                   mult_c,
    output logic                          resp_valid,
    output logic [$clog2(N_REQ)-1:0]      resp_id,
    output logic [63:0]                   resp_data,
    output logic                          idle
);

    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = $clog2(N_REQ);
    localparam int unsigned NSTG = MULT_LAT + 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

    state_e             state_q, state_d;
    logic               idle_q;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [DW-1:0]      a_q, b_q;
    logic [NSTG-1:0]    tag_vld_q;
    logic [IDW-1:0]     tag_id_q [NSTG];

    logic               gnt_vld;
    logic [IDW-1:0]     gnt_idx;
    logic [IDW-1:0]     srch_idx;
    logic [N_REQ-1:0]   ready;
    logic               in_flight;
    logic               remaining;

    // Round-robin search starting at ptr_q; grants only while running and enabled
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        srch_idx = '0;
        if (state_q == S_RUN && en) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                srch_idx = IDW'((32'(ptr_q) + k) % N_REQ);
                if (!gnt_vld && req_valid[srch_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = srch_idx;
                end
            end
        end
    end

    always_comb begin
        ready = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            ready[i] = gnt_vld && (gnt_idx == IDW'(i));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            ptr_d = (32'(gnt_idx) == N_REQ - 1) ? '0 : IDW'(gnt_idx + IDW'(1));
        end
    end

    assign in_flight = |tag_vld_q;
    // Anything still behind the output stage keeps DRAIN alive
    assign remaining = |tag_vld_q[NSTG-2:0];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (en) state_d = S_RUN;
            S_RUN:   if (!en) state_d = in_flight ? S_DRAIN : S_IDLE;
            S_DRAIN: begin
                if (en)              state_d = S_RUN;
                else if (!remaining) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idle_q    <= 1'b1;
            ptr_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            tag_vld_q <= '0;
            for (int unsigned s = 0; s < NSTG; s++) tag_id_q[s] <= '0;
        end else begin
            state_q   <= state_d;
            idle_q    <= (state_d == S_IDLE);
            ptr_q     <= ptr_d;
            if (gnt_vld) begin
                a_q <= req_a[DW*32'(gnt_idx) +: DW];
                b_q <= req_b[DW*32'(gnt_idx) +: DW];
            end
            tag_vld_q   <= {tag_vld_q[NSTG-2:0], gnt_vld};
            tag_id_q[0] <= gnt_idx;
            for (int unsigned s = 1; s < NSTG; s++) tag_id_q[s] <= tag_id_q[s-1];
        end
    end

    assign req_ready  = ready;
    assign mult_a     = a_q;
    assign mult_b     = b_q;
    assign resp_valid = tag_vld_q[NSTG-1];
    assign resp_id    = tag_id_q[NSTG-1];
    assign resp_data  = mult_c;
    assign idle       = idle_q;

`ifdef MULT_SCHED_STATS_EN
    logic [31:0] issued_q, stall_q;

    // Clear has priority over counting in the same cycle
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else if (stat_clr) begin
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            issued_q <= issued_q + 32'(gnt_vld);
            stall_q  <= stall_q + 32'((|req_valid) && !gnt_vld);
        end
    end

    assign stat_issued = issued_q;
    assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: directed requests, monitor checks responses in order.
module tb_mult_sched;

    localparam int unsigned N_REQ    = 4;
    localparam int unsigned MULT_LAT = 1;

    logic                 CLK = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ-1:0]     req_ready;
    logic [32*N_REQ-1:0]  req_a = '0;
    logic [32*N_REQ-1:0]  req_b = '0;
    logic [31:0]          mult_a, mult_b;
    logic [63:0]          mult_c = '0;
    logic                 resp_valid;
    logic [1:0]           resp_id;
    logic [63:0]          resp_data;
    logic                 idle;
`ifdef MULT_SCHED_STATS_EN
    logic                 stat_clr = 1'b0;
    logic [31:0]          stat_issued, stat_stall;
`endif

    mult_sched #(.N_REQ(N_REQ), .MULT_LAT(MULT_LAT)) dut (
        .CLK        (CLK),
        .rst_n      (rst_n),
        .en         (en),
`ifdef MULT_SCHED_STATS_EN
        .stat_clr   (stat_clr),
        .stat_issued(stat_issued),
        .stat_stall (stat_stall),
`endif
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_c     (mult_c),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .idle       (idle)
    );

    always #5 CLK = ~CLK;

    // Single-cycle multiplier model
    always @(posedge CLK) mult_c <= {32'd0, mult_a} * {32'd0, mult_b};

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every presented response must match the oldest expectation
    always @(negedge CLK) begin
        if (resp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got id %0d data %0h expected no response", resp_id, resp_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_id", 64'(resp_id), 64'(e.id));
                chk("resp_data", resp_data, e.data);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Wait (bounded) for a grant, check it goes to id, optionally log expected response
    task automatic grant(input int id, input logic [63:0] data, input string nm, input bit push,
                         output int gcyc);
        int n;
        logic [N_REQ-1:0] onehot;
        exp_t e;
        n = 0;
        @(negedge CLK);
        while (req_ready == '0 && n < 10) begin
            @(negedge CLK);
            n++;
        end
        onehot = '0;
        onehot[id] = 1'b1;
        chk(nm, 64'(req_ready), 64'(onehot));
        gcyc = cyc;
        if (push) begin
            e.id   = id;
            e.data = data;
            e.cyc  = cyc + 1 + int'(MULT_LAT);
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_mult_a", 64'(mult_a), 64'd0);
        chk("rst_mult_b", 64'(mult_b), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_idle", 64'(idle), 64'd1);
        repeat (2) @(posedge CLK);
        #1;
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, c0, cl;
        logic [N_REQ-1:0] exp_oh;
        int exp_d [4];
        exp_d = '{10, 40, 90, 160};

        // Single requester: 3*5
        @(posedge CLK);
        do_reset();
        req_a[31:0] = 32'd3;
        req_b[31:0] = 32'd5;
        req_valid   = 4'b0001;
        grant(0, 64'd15, "ready_single", 1'b1, g);
        @(posedge CLK); #1;
        req_valid = '0;
        repeat (4) @(posedge CLK);

        // All four requesters back-to-back for 8 grants
        do_reset();
        req_a     = {32'd4, 32'd3, 32'd2, 32'd1};
        req_b     = {32'd40, 32'd30, 32'd20, 32'd10};
        req_valid = 4'b1111;
        c0 = 0;
        cl = 0;
        for (int i = 0; i < 8; i++) begin
            grant(i % 4, 64'(exp_d[i % 4]), "ready_rr", 1'b1, g);
            if (i == 0) c0 = g;
            cl = g;
            @(posedge CLK); #1;
        end
        req_valid = '0;
        chk("rr_no_bubbles", 64'(cl - c0), 64'd7);
        repeat (4) @(posedge CLK);

        // Max operands on requester 3
        do_reset();
        req_a     = {32'hFFFF_FFFF, 96'd0};
        req_b     = {32'hFFFF_FFFF, 96'd0};
        req_valid = 4'b1000;
        grant(3, 64'hFFFF_FFFE_0000_0001, "ready_max", 1'b1, g);
        @(posedge CLK); #1;
        req_valid = '0;
        repeat (4) @(posedge CLK);

        // Two issues then en drops: drain, no further grants, return to idle
        do_reset();
        req_a     = {64'd0, 32'd100, 32'd7};
        req_b     = {64'd0, 32'd200, 32'd6};
        req_valid = 4'b0011;
        grant(0, 64'd42, "ready_drain0", 1'b1, g);
        @(posedge CLK); #1;
        grant(1, 64'd20000, "ready_drain1", 1'b1, g);
        @(posedge CLK); #1;
        en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            chk("drain_no_grant", 64'(req_ready), 64'd0);
            if (k == 1) chk("drain_not_idle", 64'(idle), 64'd0);
            if (k == 7) chk("drain_idle", 64'(idle), 64'd1);
        end
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        @(posedge CLK); #1;
        req_valid = '0;

        // Reset one cycle after an issue discards the in-flight request
        do_reset();
        req_a     = {96'd0, 32'd9};
        req_b     = {96'd0, 32'd9};
        req_valid = 4'b0001;
        grant(0, 64'd81, "ready_pre_rst", 1'b0, g);
        @(posedge CLK); #1;
        chk("pre_rst_mult_a", 64'(mult_a), 64'd9);
        do_reset();
        en = 1'b0;
        repeat (6) @(posedge CLK);

`ifdef MULT_SCHED_STATS_EN
        // Stats: 5 transfers then 3 stalled cycles with en low
        do_reset();
        req_a = {96'd0, 32'd2};
        req_b = {96'd0, 32'd2};
        @(posedge CLK); #1;
        req_valid = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            grant(0, 64'd4, "ready_stats", 1'b1, g);
            @(posedge CLK); #1;
        end
        en = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        req_valid = '0;
        @(negedge CLK);
        chk("stat_issued", 64'(stat_issued), 64'd5);
        chk("stat_stall", 64'(stat_stall), 64'd3);
        @(posedge CLK); #1;
        stat_clr = 1'b1;
        @(posedge CLK); #1;
        stat_clr = 1'b0;
        @(negedge CLK);
        chk("stat_issued_clr", 64'(stat_issued), 64'd0);
        chk("stat_stall_clr", 64'(stat_stall), 64'd0);
        repeat (4) @(posedge CLK);
`endif

        @(negedge CLK);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
